// File: rtl/rf_ctrl_pkg.sv
// Shared widths and defaults for the register-file writeback controller.
// Also holds the helper that turns a write request to x0 into no request.
package rf_ctrl_pkg;
   localparam int XLEN             = 32;
   localparam int REG_AW           = 5;
   localparam int NREG             = 32;
   localparam int STARVE_LIMIT_DEF = 3;

   // x0 is hardwired to zero, so a request aimed at it is no request at all.
   function automatic logic is_req(input logic en, input logic [REG_AW-1:0] idx);
      return en && (idx != '0);
   endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Busy bits for registers whose long-latency result is still outstanding.
// Provides three independent read ports; x0 never reads busy.
module rf_scoreboard
   import rf_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              set,
   input  logic [REG_AW-1:0] set_idx,
   input  logic              clr,
   input  logic [REG_AW-1:0] clr_idx,
   input  logic [REG_AW-1:0] rd_idx1,
   input  logic [REG_AW-1:0] rd_idx2,
   input  logic [REG_AW-1:0] rd_idx3,
   output logic              busy1,
   output logic              busy2,
   output logic              busy3
);
   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;

   // NOTE: blocking assignments in always_comb execute in order, so the set
   // written after the clear wins when both target the same register.
   always_comb begin
      w_busy_nxt = r_busy;
      if (clr) w_busy_nxt[clr_idx] = 1'b0;
      if (set) w_busy_nxt[set_idx] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) r_busy <= '0;
      else     r_busy <= w_busy_nxt;
   end

   assign busy1 = r_busy[rd_idx1];
   assign busy2 = r_busy[rd_idx2];
   assign busy3 = r_busy[rd_idx3];
endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-port arbiter: pipeline WB always wins, MDU results go
// direct or through a one-entry skid buffer, and hazards stall the front end.
module rf_wb_ctrl
   import rf_ctrl_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_wR,
   input  logic [XLEN-1:0]   wb_wD,
   input  logic              mdu_valid,
   input  logic [REG_AW-1:0] mdu_wR,
   input  logic [XLEN-1:0]   mdu_wD,
   output logic              mdu_ready,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_wR,
   input  logic [REG_AW-1:0] rR1,
   input  logic [REG_AW-1:0] rR2,
   output logic              we,
   output logic [REG_AW-1:0] wR,
   output logic [XLEN-1:0]   wD,
   output logic              stall
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic              r_buf_valid;
   logic [REG_AW-1:0] r_buf_wR;
   logic [XLEN-1:0]   r_buf_wD;
   logic [CNT_W-1:0]  r_starve;

   logic w_wb_req, w_mdu_req, w_drain, w_direct, w_capture;
   logic w_busy1, w_busy2, w_busy3;

   assign mdu_ready = !r_buf_valid;
   assign w_wb_req  = is_req(wb_we, wb_wR);
   assign w_mdu_req = is_req(mdu_valid, mdu_wR) && !r_buf_valid;
   assign w_drain   = r_buf_valid && !w_wb_req;
   assign w_direct  = w_mdu_req && !w_wb_req;
   assign w_capture = w_mdu_req && w_wb_req;

   // NOTE: every output gets a default first so no path leaves a latch behind.
   always_comb begin
      we = 1'b0;
      wR = '0;
      wD = '0;
      if (w_wb_req) begin
         we = 1'b1;
         wR = wb_wR;
         wD = wb_wD;
      end else if (r_buf_valid) begin
         we = 1'b1;
         wR = r_buf_wR;
         wD = r_buf_wD;
      end else if (w_mdu_req) begin
         we = 1'b1;
         wR = mdu_wR;
         wD = mdu_wD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf_valid <= 1'b0;
         r_starve    <= '0;
      end else begin
         if (w_capture)    r_buf_valid <= 1'b1;
         else if (w_drain) r_buf_valid <= 1'b0;

         if (r_buf_valid && w_wb_req) begin
            if (r_starve != CNT_W'(STARVE_LIMIT)) r_starve <= r_starve + 1'b1;
         end else begin
            r_starve <= '0;
         end
      end
   end

   // NOTE: payload registers carry no reset; r_buf_valid alone qualifies them.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_buf_wR <= mdu_wR;
         r_buf_wD <= mdu_wD;
      end
   end

   rf_scoreboard u_sb (
      .clk     (clk),
      .rst     (rst),
      .set     (is_req(iss_valid, iss_wR)),
      .set_idx (iss_wR),
      .clr     (w_drain || w_direct),
      .clr_idx (w_drain ? r_buf_wR : mdu_wR),
      .rd_idx1 (rR1),
      .rd_idx2 (rR2),
      .rd_idx3 (iss_wR),
      .busy1   (w_busy1),
      .busy2   (w_busy2),
      .busy3   (w_busy3)
   );

   assign stall = w_busy1 || w_busy2 || (iss_valid && w_busy3)
                  || (r_starve == CNT_W'(STARVE_LIMIT));
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Scoreboard bench for rf_wb_ctrl: directed scenarios then random traffic,
// with expected writes queued by the driver and consumed by a monitor.
module tb_rf_wb_ctrl;
   import rf_ctrl_pkg::*;

   localparam int LIMIT = STARVE_LIMIT_DEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we, mdu_valid, iss_valid;
   logic [4:0]  wb_wR, mdu_wR, iss_wR, rR1, rR2;
   logic [31:0] wb_wD, mdu_wD;
   logic        mdu_ready, we, stall;
   logic [4:0]  wR;
   logic [31:0] wD;

   always #5 clk = ~clk;

   rf_wb_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_wR(wb_wR), .wb_wD(wb_wD),
      .mdu_valid(mdu_valid), .mdu_wR(mdu_wR), .mdu_wD(mdu_wD), .mdu_ready(mdu_ready),
      .iss_valid(iss_valid), .iss_wR(iss_wR),
      .rR1(rR1), .rR2(rR2),
      .we(we), .wR(wR), .wD(wD), .stall(stall)
   );

   typedef struct {
      int          cyc;
      logic [4:0]  r;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];   // expected RF writes, tagged with the cycle they must appear
   wr_t pend[$];    // model: MDU results parked while WB owns the port
   bit  busy_m[32]; // model: registers awaiting a long-latency result
   int  starve;
   int  cyc;
   bit  mon_en;
   bit  exp_stall, exp_ready;
   int  n_checks, n_pass;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // One clock of stimulus; the model predicts this cycle's outputs, then advances.
   task automatic step(input bit r, input bit wwe, input logic [4:0] wwr, input logic [31:0] wwd,
                       input bit mv, input logic [4:0] mr, input logic [31:0] md,
                       input bit iv, input logic [4:0] ir, input logic [4:0] r1, input logic [4:0] r2);
      bit  wb_req, mdu_req;
      wr_t w;
      @(posedge clk);
      #1;
      cyc++;
      rst = r; wb_we = wwe; wb_wR = wwr; wb_wD = wwd;
      mdu_valid = mv; mdu_wR = mr; mdu_wD = md;
      iss_valid = iv; iss_wR = ir; rR1 = r1; rR2 = r2;

      wb_req    = wwe && wwr != 0;
      exp_ready = (pend.size() == 0);
      mdu_req   = mv && exp_ready && mr != 0;
      exp_stall = busy_m[r1] || busy_m[r2] || (iv && busy_m[ir]) || (starve == LIMIT);

      w.cyc = cyc;
      if (wb_req) begin
         w.r = wwr; w.d = wwd; exp_q.push_back(w);
      end else if (pend.size() > 0) begin
         w.r = pend[0].r; w.d = pend[0].d; exp_q.push_back(w);
      end else if (mdu_req) begin
         w.r = mr; w.d = md; exp_q.push_back(w);
      end

      if (r) begin
         foreach (busy_m[i]) busy_m[i] = 1'b0;
         pend.delete();
         starve = 0;
      end else begin
         if (pend.size() > 0 && !wb_req) begin
            busy_m[pend[0].r] = 1'b0;
            void'(pend.pop_front());
            starve = 0;
         end else if (pend.size() > 0) begin
            starve = (starve < LIMIT) ? starve + 1 : LIMIT;
         end else begin
            starve = 0;
         end
         if (mdu_req) begin
            if (wb_req) begin
               w.r = mr; w.d = md; pend.push_back(w);
            end else begin
               busy_m[mr] = 1'b0;
            end
         end
         if (iv && ir != 0) busy_m[ir] = 1'b1;
      end
   endtask

   task automatic idle(input logic [4:0] r1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("stall", stall, exp_stall);
         check("mdu_ready", mdu_ready, exp_ready);
         if (we) begin
            if (exp_q.size() == 0) begin
               check("spurious_we", we, 1'b0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_cycle", cyc, e.cyc);
               check("wR", wR, e.r);
               check("wD", wD, e.d);
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            check("missing_we", we, 1'b1);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      logic        hv;
      logic [4:0]  hr;
      logic [31:0] hd;
      n_checks = 0; n_pass = 0; cyc = 0; mon_en = 0; starve = 0;
      foreach (busy_m[i]) busy_m[i] = 1'b0;

      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      exp_q.delete();
      mon_en = 1;

      // Post-reset idle outputs
      idle(0);
      @(negedge clk);
      check("rst_we", we, 0); check("rst_wR", wR, 0); check("rst_wD", wD, 0);
      check("rst_ready", mdu_ready, 1); check("rst_stall", stall, 0);

      // Issue to x5, dependent read stalls, direct MDU write clears it
      step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
      idle(5);
      @(negedge clk); check("raw_stall", stall, 1);
      step(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
      @(negedge clk);
      check("direct_we", we, 1); check("direct_wR", wR, 5); check("direct_wD", wD, 32'hDEADBEEF);
      idle(5);
      @(negedge clk); check("raw_release", stall, 0);

      // WB collides with MDU: WB wins, MDU result buffered then drained
      step(0, 1, 3, 32'h11, 1, 6, 32'h66, 0, 0, 0, 0);
      @(negedge clk); check("coll_wR", wR, 3); check("coll_wD", wD, 32'h11);
      step(0, 1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); check("coll_ready", mdu_ready, 0);
      idle(0);
      @(negedge clk); check("drain_wR", wR, 6); check("drain_wD", wD, 32'h66);

      // Starvation: stall after exactly LIMIT cycles of held WB
      step(0, 1, 3, 32'h1, 1, 8, 32'h88, 0, 0, 0, 0);
      for (int i = 0; i < LIMIT; i++) begin
         step(0, 1, 3, 32'h2, 0, 0, 0, 0, 0, 0, 0);
         @(negedge clk); check("starve_pre", stall, 0);
      end
      step(0, 1, 3, 32'h3, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); check("starve_stall", stall, 1);
      idle(0);
      @(negedge clk); check("starve_drain_wR", wR, 8);
      idle(0);
      @(negedge clk); check("starve_clear", stall, 0);

      // x0 requests are ignored
      step(0, 1, 0, 32'h5, 0, 0, 0, 1, 0, 0, 0);
      @(negedge clk); check("x0_we", we, 0);
      idle(0);
      @(negedge clk); check("x0_stall", stall, 0);

      // Set beats clear on x7
      step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
      step(0, 0, 0, 0, 1, 7, 32'h77, 1, 7, 0, 0);
      idle(7);
      @(negedge clk); check("set_wins", stall, 1);
      step(0, 0, 0, 0, 1, 7, 32'h78, 0, 0, 0, 0);

      // Reset with buffered result for busy x9
      step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
      step(0, 1, 2, 32'h22, 1, 9, 32'h99, 0, 0, 0, 0);
      step(1, 1, 2, 32'h23, 0, 0, 0, 0, 0, 0, 0);
      idle(9);
      @(negedge clk);
      check("mrst_ready", mdu_ready, 1); check("mrst_stall", stall, 0); check("mrst_we", we, 0);

      // Random traffic; the MDU holds its request until accepted
      hv = 0; hr = 0; hd = 0;
      for (int n = 0; n < 2000; n++) begin
         if (!hv && ($urandom % 3 == 0)) begin
            hv = 1; hr = 5'($urandom_range(0, 7)); hd = $urandom;
         end
         step(($urandom % 250) == 0,
              ($urandom % 10) < 6, 5'($urandom_range(0, 7)), $urandom,
              hv, hr, hd,
              ($urandom % 4) == 0, 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         if (hv && (exp_ready || rst)) hv = 0;
      end

      repeat (4) idle(0);
      @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/rf_wb_ctrl.md
RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter STARVE_LIMIT, default 3, SHALL set the consecutive buffered-hold cycles before a starvation stall.
REQ-003 Port clk, input, 1, SHALL be the sole clock; all state updates on posedge.
REQ-004 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-005 Ports wb_we/wb_wR/wb_wD, input, 1/5/32, SHALL be the pipeline writeback request.
REQ-006 Ports mdu_valid/mdu_wR/mdu_wD, input, 1/5/32, SHALL be the multi-cycle unit result request.
REQ-007 Port mdu_ready, output, 1, SHALL accept an MDU result when high.
REQ-008 Ports iss_valid/iss_wR, input, 1/5, SHALL report issue of a long-latency op and its destination.
REQ-009 Ports rR1/rR2, input, 5 each, SHALL carry the ID-stage source register numbers.
REQ-010 Ports we/wR/wD, output, 1/5/32, SHALL drive the register-file write port.
REQ-011 Port stall, output, 1, SHALL freeze the IF/ID front end when high.

Function
REQ-012 The wb_* request SHALL have absolute priority on the write port.
- The pipeline cannot be stalled at WB.
REQ-013 we/wR/wD SHALL be a combinational mux with zero latency.
- Priority order: wb_* request, then the buffer entry, then a direct MDU result.
REQ-014 A write request with wR==0 SHALL be treated as no request.
- It never drives we=1.
REQ-015 The block SHALL hold a one-entry skid buffer (buf_valid, buf_wR, buf_wD), and mdu_ready SHALL equal !buf_valid.
REQ-016 An accepted MDU result (mdu_valid & mdu_ready) SHALL be handled by write-port availability:
- Written directly the same cycle when wb_we==0.
- Captured into the buffer at the clock edge when wb_we==1.
REQ-017 A valid buffer entry SHALL be written and cleared in the first cycle with wb_we==0.
REQ-018 A 32-bit busy scoreboard SHALL track registers awaiting a long-latency result:
- Bit set on iss_valid & iss_wR!=0.
- Bit cleared when the MDU result for that register is written to the RF.
- A result sitting in the buffer leaves its register busy.
REQ-019 When a set and a clear target the same register in one cycle, the set SHALL win.
REQ-020 Bit 0 of the scoreboard SHALL always read 0.
REQ-021 stall SHALL be combinational and asserted when any of these holds:
- busy[rR1] is set.
- busy[rR2] is set.
- iss_valid & busy[iss_wR] (WAW hazard).
- The starvation counter equals STARVE_LIMIT.
REQ-022 A saturating starvation counter SHALL behave as follows:
- Increments each cycle buf_valid & wb_we.
- Clears whenever buf_valid==0 or the buffer drains.
- stall for starvation forces bubbles into WB so the buffer drains.
REQ-023 mdu_valid with mdu_ready==0 SHALL leave all state unchanged.
- The MDU must hold its request.

Reset
REQ-024 On rst the block SHALL clear buf_valid, the scoreboard and the starvation counter in the same edge.
- Any in-flight MDU result is discarded.
REQ-025 In the cycle following reset, outputs SHALL be: we=0, wR=0, wD=0, mdu_ready=1, stall=0 (given idle inputs).
REQ-026 Reset asserted mid-operation SHALL override all simultaneous set/capture/drain events.

Structure
REQ-027 A shared package rf_ctrl_pkg SHALL hold the width constants and the default parameter value:
- XLEN=32, REG_AW=5, NREG=32.
- STARVE_LIMIT default value.
REQ-028 The scoreboard SHALL be a sub-module rf_scoreboard with the following ports:
- Inputs: set/set_idx, clr/clr_idx, rd_idx1/rd_idx2/rd_idx3.
- Outputs: three busy bits.
REQ-029 The arbitration mux, skid buffer and starvation counter SHALL reside in rf_wb_ctrl.

Verification
REQ-030 iss_valid=1, iss_wR=5; next cycle rR1=5 -> stall=1. Then mdu_valid=1, mdu_wR=5, mdu_wD=0xDEADBEEF, wb_we=0 -> same cycle we=1, wR=5, wD=0xDEADBEEF; next cycle stall=0.
REQ-031 mdu_valid and wb_we=1 (wb_wR=3, wb_wD=0x11) in the same cycle -> write goes to x3 with 0x11; mdu_ready=0 next cycle; buffered result is written in the first wb_we=0 cycle.
REQ-032 Buffer occupied with wb_we held at 1 -> stall asserts after exactly 3 cycles; after wb_we drops, the buffer drains, the counter clears and stall=0.
REQ-033 iss_valid with iss_wR=0, and wb_we=1 with wb_wR=0 -> scoreboard unchanged, we=0.
REQ-034 Busy on x7, then MDU write to x7 and new iss_wR=7 in the same cycle -> busy[7] stays 1.
REQ-035 rst asserted while buf_valid=1 and busy[9]=1 -> next cycle mdu_ready=1, stall=0, we=0, no write to x9.
